// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the hazard-controller state type.
package riscv_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OPC_W  = 7;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Fetch/EX/decode-side signals of the hazard controller; slave is the controller.
interface decode_hazard_ctrl_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
);
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [PC_W-1:0]   if_pc;
  logic              ex_mem_read;
  logic [4:0]        ex_rd;
  logic              branch_taken;
  logic              id_valid;
  logic [31:0]       id_inst;
  logic [PC_W-1:0]   id_pc;
  logic              pc_write;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output if_valid, if_inst, if_pc, ex_mem_read, ex_rd, branch_taken,
    input  id_valid, id_inst, id_pc, pc_write, idex_bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_valid, if_inst, if_pc, ex_mem_read, ex_rd, branch_taken,
    output id_valid, id_inst, id_pc, pc_write, idex_bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/decode_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect: source-register usage decode plus compare against the EX load target.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              hazard
);

  logic w_rs1_used;
  logic w_rs2_used;
  logic w_rs1_match;
  logic w_rs2_match;
  logic w_unused_fields;

  // Unknown opcodes read no registers, so they can never cause a stall.
  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (inst[6:0])
      OP_R, OP_STORE, OP_BRANCH: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: w_rs1_used = 1'b1;
      default: begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
      end
    endcase
  end

  assign w_rs1_match = w_rs1_used & (inst[19:15] == ex_rd);
  assign w_rs2_match = w_rs2_used & (inst[24:20] == ex_rd);
  assign hazard      = ex_mem_read & (ex_rd != REG_W'(0)) & (w_rs1_match | w_rs2_match);

  assign w_unused_fields = ^{inst[31:25], inst[14:7]};

endmodule

// File: rtl/decode_hazard_ctrl.sv
// IF/ID register owner and decode-stage sequencer: load-use stalls, branch flushes, perf counters.
module decode_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned STALL_CYC = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_hazard_ctrl_if.slave  bus
);

  localparam int unsigned DC_W = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hz_state_t          r_state;
  logic [DC_W-1:0]    r_dcnt;
  logic               r_id_valid;
  logic [INST_W-1:0]  r_id_inst;
  logic [PC_W-1:0]    r_id_pc;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic w_lu_hazard;
  logic w_hazard;
  logic w_hold;

  load_use_detect u_load_use_detect (
    .inst        (r_id_inst),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .hazard      (w_lu_hazard)
  );

  // EX inputs only matter in RUN; a STALL already owns the pipeline.
  assign w_hazard = (r_state == RUN) & r_id_valid & w_lu_hazard;
  assign w_hold   = (r_state == STALL) | w_hazard;

  assign bus.pc_write    = bus.branch_taken | ~w_hold;
  assign bus.idex_bubble = bus.branch_taken | w_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_dcnt      <= '0;
      r_id_valid  <= 1'b0;
      r_id_inst   <= NOP_INST;
      r_id_pc     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.branch_taken) begin
      r_state    <= RUN;
      r_dcnt     <= '0;
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
      r_id_pc    <= '0;
      if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (r_state == STALL) begin
      if (r_dcnt == DC_W'(1)) begin
        r_state <= RUN;
        r_dcnt  <= '0;
      end else begin
        r_dcnt <= r_dcnt - DC_W'(1);
      end
      if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else if (w_hazard) begin
      // Single-cycle stalls stay in RUN and re-check against the bubble now in EX.
      if (STALL_CYC > 1) begin
        r_state <= STALL;
        r_dcnt  <= DC_W'(STALL_CYC - 1);
      end
      if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_id_valid <= bus.if_valid;
      r_id_inst  <= bus.if_valid ? bus.if_inst : NOP_INST;
      r_id_pc    <= bus.if_pc;
    end
  end

  assign bus.id_valid  = r_id_valid;
  assign bus.id_inst   = r_id_inst;
  assign bus.id_pc     = r_id_pc;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: three configurations driven in lockstep against a cycle model.
module tb_decode_hazard_ctrl;
  import riscv_pkg::*;

  localparam int NDUT = 3;
  localparam int SC   [NDUT] = '{1, 3, 1};
  localparam int CMAX [NDUT] = '{65535, 65535, 3};

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] NEXT = 32'h00418233;
  localparam logic [31:0] SW   = 32'h00112023;
  localparam logic [31:0] LUI  = 32'h000082B7;
  localparam logic [31:0] ADD0 = 32'h000001B3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_reset = 1'b1;
  logic        t_valid = 1'b0, t_mr = 1'b0, t_br = 1'b0;
  logic [31:0] t_inst = NOP_INST, t_pc = '0;
  logic [4:0]  t_rd = '0;

  int n_tests = 0;
  int n_fail  = 0;

  decode_hazard_ctrl_if #(.PC_W(32), .CNT_W(16)) bi0 ();
  decode_hazard_ctrl_if #(.PC_W(32), .CNT_W(16)) bi1 ();
  decode_hazard_ctrl_if #(.PC_W(32), .CNT_W(2))  bi2 ();

  assign bi0.if_valid = t_valid; assign bi0.if_inst = t_inst; assign bi0.if_pc = t_pc;
  assign bi0.ex_mem_read = t_mr; assign bi0.ex_rd = t_rd;     assign bi0.branch_taken = t_br;
  assign bi1.if_valid = t_valid; assign bi1.if_inst = t_inst; assign bi1.if_pc = t_pc;
  assign bi1.ex_mem_read = t_mr; assign bi1.ex_rd = t_rd;     assign bi1.branch_taken = t_br;
  assign bi2.if_valid = t_valid; assign bi2.if_inst = t_inst; assign bi2.if_pc = t_pc;
  assign bi2.ex_mem_read = t_mr; assign bi2.ex_rd = t_rd;     assign bi2.branch_taken = t_br;

  decode_hazard_ctrl #(.PC_W(32), .STALL_CYC(1), .CNT_W(16)) dut0 (.clk(clk), .reset(t_reset), .bus(bi0));
  decode_hazard_ctrl #(.PC_W(32), .STALL_CYC(3), .CNT_W(16)) dut1 (.clk(clk), .reset(t_reset), .bus(bi1));
  decode_hazard_ctrl #(.PC_W(32), .STALL_CYC(1), .CNT_W(2))  dut2 (.clk(clk), .reset(t_reset), .bus(bi2));

  logic        o_valid [NDUT];
  logic        o_pcw   [NDUT];
  logic        o_bub   [NDUT];
  logic [31:0] o_inst  [NDUT];
  logic [31:0] o_pc    [NDUT];
  int          o_scnt  [NDUT];
  int          o_fcnt  [NDUT];

  always_comb begin
    o_valid[0] = bi0.id_valid; o_pcw[0] = bi0.pc_write; o_bub[0] = bi0.idex_bubble;
    o_inst[0]  = bi0.id_inst;  o_pc[0]  = bi0.id_pc;
    o_scnt[0]  = 32'(bi0.stall_cnt); o_fcnt[0] = 32'(bi0.flush_cnt);
    o_valid[1] = bi1.id_valid; o_pcw[1] = bi1.pc_write; o_bub[1] = bi1.idex_bubble;
    o_inst[1]  = bi1.id_inst;  o_pc[1]  = bi1.id_pc;
    o_scnt[1]  = 32'(bi1.stall_cnt); o_fcnt[1] = 32'(bi1.flush_cnt);
    o_valid[2] = bi2.id_valid; o_pcw[2] = bi2.pc_write; o_bub[2] = bi2.idex_bubble;
    o_inst[2]  = bi2.id_inst;  o_pc[2]  = bi2.id_pc;
    o_scnt[2]  = 32'(bi2.stall_cnt); o_fcnt[2] = 32'(bi2.flush_cnt);
  end

  // Reference model: IF/ID contents, remaining stall cycles, and plain integer counters.
  bit          m_valid [NDUT];
  logic [31:0] m_inst  [NDUT];
  logic [31:0] m_pc    [NDUT];
  int          m_left  [NDUT];
  int          m_scnt  [NDUT];
  int          m_fcnt  [NDUT];

  function automatic bit reads_rs1(logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic bit reads_rs2(logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

  function automatic bit m_stalls(int d);
    bit dep;
    if (m_left[d] > 0) return 1'b1;
    dep = (reads_rs1(m_inst[d][6:0]) && m_inst[d][19:15] == t_rd) ||
          (reads_rs2(m_inst[d][6:0]) && m_inst[d][24:20] == t_rd);
    return m_valid[d] && t_mr && (t_rd != 5'd0) && dep;
  endfunction

  task automatic tick();
    for (int d = 0; d < NDUT; d++) begin
      bit st;
      st = m_stalls(d);
      if (t_reset) begin
        m_valid[d] = 1'b0; m_inst[d] = NOP_INST; m_pc[d] = '0;
        m_left[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
      end else if (t_br) begin
        m_valid[d] = 1'b0; m_inst[d] = NOP_INST; m_pc[d] = '0; m_left[d] = 0;
        m_fcnt[d] = (m_fcnt[d] + 1 > CMAX[d]) ? CMAX[d] : m_fcnt[d] + 1;
      end else if (st) begin
        m_left[d] = (m_left[d] > 0) ? m_left[d] - 1 : SC[d] - 1;
        m_scnt[d] = (m_scnt[d] + 1 > CMAX[d]) ? CMAX[d] : m_scnt[d] + 1;
      end else begin
        m_valid[d] = t_valid; m_inst[d] = t_valid ? t_inst : NOP_INST; m_pc[d] = t_pc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] inst, logic [31:0] pc, bit mr, logic [4:0] rd, bit br);
    t_valid = v; t_inst = inst; t_pc = pc; t_mr = mr; t_rd = rd; t_br = br;
  endtask

  task automatic apply_reset();
    t_reset = 1'b1;
    drive(1'b0, NOP_INST, '0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    t_reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int d = 0; d < NDUT; d++) begin
      n_tests++; if (o_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got=%0b exp=0", d, o_valid[d]); end
      n_tests++; if (o_inst[d] !== NOP_INST) begin n_fail++; $display("FAIL reset_inst[%0d] got=%h exp=%h", d, o_inst[d], NOP_INST); end
      n_tests++; if (o_pc[d] !== 32'd0) begin n_fail++; $display("FAIL reset_pc[%0d] got=%h exp=0", d, o_pc[d]); end
      n_tests++; if (o_scnt[d] != 0 || o_fcnt[d] != 0) begin n_fail++; $display("FAIL reset_cnt[%0d] got=%0d/%0d exp=0/0", d, o_scnt[d], o_fcnt[d]); end
      n_tests++; if (o_pcw[d] !== 1'b1 || o_bub[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ctl[%0d] pcw/bub got=%0b%0b exp=10", d, o_pcw[d], o_bub[d]); end
    end
  endtask

  task automatic test_load_use_rs1();
    apply_reset();
    drive(1'b1, ADD, 32'h100, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, NEXT, 32'h104, 1'b1, 5'd1, 1'b0); #1;
    n_tests++; if (o_pcw[0] !== 1'b0 || o_bub[0] !== 1'b1) begin n_fail++; $display("FAIL rs1_stall pcw/bub got=%0b%0b exp=01", o_pcw[0], o_bub[0]); end
    tick();
    drive(1'b1, NEXT, 32'h104, 1'b0, 5'd0, 1'b0); #1;
    n_tests++; if (o_pcw[0] !== 1'b1 || o_bub[0] !== 1'b0) begin n_fail++; $display("FAIL rs1_release pcw/bub got=%0b%0b exp=10", o_pcw[0], o_bub[0]); end
    n_tests++; if (o_inst[0] !== ADD || o_valid[0] !== 1'b1) begin n_fail++; $display("FAIL rs1_held inst=%h v=%0b exp=%h v=1", o_inst[0], o_valid[0], ADD); end
    n_tests++; if (o_scnt[0] != 1) begin n_fail++; $display("FAIL rs1_scnt got=%0d exp=1", o_scnt[0]); end
    tick();
    n_tests++; if (o_inst[0] !== NEXT || o_pc[0] !== 32'h104) begin n_fail++; $display("FAIL rs1_next inst=%h pc=%h exp=%h/104", o_inst[0], o_pc[0], NEXT); end
  endtask

  task automatic test_rs2_no_false();
    apply_reset();
    drive(1'b1, SW, 32'h200, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, LUI, 32'h204, 1'b1, 5'd1, 1'b0); #1;
    n_tests++; if (o_pcw[0] !== 1'b0) begin n_fail++; $display("FAIL rs2_stall pcw got=%0b exp=0", o_pcw[0]); end
    tick();
    drive(1'b1, LUI, 32'h204, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, ADD0, 32'h208, 1'b1, 5'd1, 1'b0); #1;
    n_tests++; if (o_inst[0] !== LUI) begin n_fail++; $display("FAIL lui_loaded got=%h exp=%h", o_inst[0], LUI); end
    n_tests++; if (o_pcw[0] !== 1'b1 || o_bub[0] !== 1'b0) begin n_fail++; $display("FAIL lui_nostall pcw/bub got=%0b%0b exp=10", o_pcw[0], o_bub[0]); end
    tick();
    drive(1'b1, NOP_INST, 32'h20C, 1'b1, 5'd0, 1'b0); #1;
    n_tests++; if (o_inst[0] !== ADD0 || o_pcw[0] !== 1'b1) begin n_fail++; $display("FAIL rd0_nostall inst=%h pcw=%0b exp=%h/1", o_inst[0], o_pcw[0], ADD0); end
    n_tests++; if (o_scnt[0] != 1) begin n_fail++; $display("FAIL rs2_scnt got=%0d exp=1", o_scnt[0]); end
  endtask

  task automatic test_multi_stall();
    apply_reset();
    drive(1'b1, ADD, 32'h300, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, NEXT, 32'h304, 1'b1, 5'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (o_pcw[1] !== 1'b0 || o_bub[1] !== 1'b1) begin n_fail++; $display("FAIL multi_stall%0d pcw/bub got=%0b%0b exp=01", k, o_pcw[1], o_bub[1]); end
      tick();
      drive(1'b1, NEXT, 32'h304, 1'b0, 5'd0, 1'b0);
    end
    #1;
    n_tests++; if (o_pcw[1] !== 1'b1 || o_scnt[1] != 3 || o_inst[1] !== ADD) begin n_fail++; $display("FAIL multi_done pcw=%0b scnt=%0d inst=%h exp=1/3/%h", o_pcw[1], o_scnt[1], o_inst[1], ADD); end
    drive(1'b1, ADD, 32'h308, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, NEXT, 32'h30C, 1'b1, 5'd1, 1'b0); #1;
    n_tests++; if (o_pcw[1] !== 1'b0) begin n_fail++; $display("FAIL multi_restall pcw got=%0b exp=0", o_pcw[1]); end
    tick();
    drive(1'b1, NEXT, 32'h30C, 1'b0, 5'd0, 1'b0);
    t_reset = 1'b1; tick(); t_reset = 1'b0; #1;
    n_tests++; if (o_pcw[1] !== 1'b1 || o_bub[1] !== 1'b0) begin n_fail++; $display("FAIL abort_ctl pcw/bub got=%0b%0b exp=10", o_pcw[1], o_bub[1]); end
    n_tests++; if (o_scnt[1] != 0 || o_fcnt[1] != 0 || o_valid[1] !== 1'b0) begin n_fail++; $display("FAIL abort_state scnt=%0d fcnt=%0d v=%0b exp=0/0/0", o_scnt[1], o_fcnt[1], o_valid[1]); end
  endtask

  task automatic test_branch_vs_hazard();
    apply_reset();
    drive(1'b1, ADD, 32'h400, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, NEXT, 32'h404, 1'b1, 5'd1, 1'b1); #1;
    n_tests++; if (o_pcw[0] !== 1'b1 || o_bub[0] !== 1'b1) begin n_fail++; $display("FAIL br_hz_ctl pcw/bub got=%0b%0b exp=11", o_pcw[0], o_bub[0]); end
    tick();
    drive(1'b0, NOP_INST, 32'h0, 1'b0, 5'd0, 1'b0); #1;
    n_tests++; if (o_valid[0] !== 1'b0 || o_inst[0] !== NOP_INST || o_pc[0] !== 32'd0) begin n_fail++; $display("FAIL br_hz_flush v=%0b inst=%h pc=%h exp=0/%h/0", o_valid[0], o_inst[0], o_pc[0], NOP_INST); end
    n_tests++; if (o_fcnt[0] != 1 || o_scnt[0] != 0) begin n_fail++; $display("FAIL br_hz_cnt f=%0d s=%0d exp=1/0", o_fcnt[0], o_scnt[0]); end
  endtask

  task automatic test_branch_in_stall();
    apply_reset();
    drive(1'b1, ADD, 32'h500, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, NEXT, 32'h504, 1'b1, 5'd1, 1'b0); #1;
    n_tests++; if (o_pcw[1] !== 1'b0) begin n_fail++; $display("FAIL brst_stall pcw got=%0b exp=0", o_pcw[1]); end
    tick();
    drive(1'b1, NEXT, 32'h504, 1'b0, 5'd0, 1'b1); #1;
    n_tests++; if (o_pcw[1] !== 1'b1 || o_bub[1] !== 1'b1) begin n_fail++; $display("FAIL brst_ctl pcw/bub got=%0b%0b exp=11", o_pcw[1], o_bub[1]); end
    tick();
    drive(1'b0, NOP_INST, 32'h0, 1'b0, 5'd0, 1'b0); #1;
    n_tests++; if (o_pcw[1] !== 1'b1 || o_bub[1] !== 1'b0 || o_valid[1] !== 1'b0) begin n_fail++; $display("FAIL brst_exit pcw=%0b bub=%0b v=%0b exp=1/0/0", o_pcw[1], o_bub[1], o_valid[1]); end
    n_tests++; if (o_fcnt[1] != 1 || o_scnt[1] != 1) begin n_fail++; $display("FAIL brst_cnt f=%0d s=%0d exp=1/1", o_fcnt[1], o_scnt[1]); end
  endtask

  task automatic test_saturation();
    apply_reset();
    drive(1'b1, ADD, 32'h600, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, NEXT, 32'h604, 1'b1, 5'd1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++; if (o_scnt[2] != ((k > 3) ? 3 : k) || o_inst[2] !== ADD) begin n_fail++; $display("FAIL sat_stall%0d got=%0d inst=%h exp=%0d/%h", k, o_scnt[2], o_inst[2], (k > 3) ? 3 : k, ADD); end
    end
    drive(1'b0, NOP_INST, 32'h0, 1'b0, 5'd0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++; if (o_fcnt[2] != ((k > 3) ? 3 : k) || o_scnt[2] != 3) begin n_fail++; $display("FAIL sat_flush%0d f=%0d s=%0d exp=%0d/3", k, o_fcnt[2], o_scnt[2], (k > 3) ? 3 : k); end
    end
    t_br = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h7F};
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      r[24:20] = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[6:0]   = ops[$urandom_range(0, 9)];
      drive(1'($urandom_range(0, 3) != 0), r, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
      t_reset = 1'($urandom_range(0, 59) == 0);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        n_tests++; if (o_pcw[d] !== !(m_stalls(d) && !t_br)) begin n_fail++; $display("FAIL rnd_pcw[%0d] c%0d got=%0b exp=%0b", d, c, o_pcw[d], !(m_stalls(d) && !t_br)); end
        n_tests++; if (o_bub[d] !== (m_stalls(d) || t_br)) begin n_fail++; $display("FAIL rnd_bub[%0d] c%0d got=%0b exp=%0b", d, c, o_bub[d], m_stalls(d) || t_br); end
        n_tests++; if (o_valid[d] !== m_valid[d] || o_inst[d] !== m_inst[d] || o_pc[d] !== m_pc[d]) begin n_fail++; $display("FAIL rnd_ifid[%0d] c%0d got=%0b/%h/%h exp=%0b/%h/%h", d, c, o_valid[d], o_inst[d], o_pc[d], m_valid[d], m_inst[d], m_pc[d]); end
        n_tests++; if (o_scnt[d] != m_scnt[d] || o_fcnt[d] != m_fcnt[d]) begin n_fail++; $display("FAIL rnd_cnt[%0d] c%0d got=%0d/%0d exp=%0d/%0d", d, c, o_scnt[d], o_fcnt[d], m_scnt[d], m_fcnt[d]); end
      end
      tick();
    end
    t_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use_rs1();
    test_rs2_no_false();
    test_multi_stall();
    test_branch_vs_hazard();
    test_branch_in_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
Owns the IF/ID pipeline register and sequences the decode stage that feeds the immediate generator and the register file. Detects load-use hazards and holds fetch and decode for a configurable number of cycles. Injects bubbles into ID/EX and flushes IF/ID when EX resolves a taken branch. Keeps saturating stall and flush counters for performance debug.

Parameters:
PC_W, 32, width of the program-counter path
STALL_CYC, 1, stall cycles per load-use hazard (≥1; data-memory latency)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
if_valid  in  1  fetch presents a valid instruction
if_inst  in  32  fetched instruction word
if_pc  in  PC_W  PC of the fetched instruction
ex_mem_read  in  1  instruction currently in EX is a load
ex_rd  in  5  destination register of the EX instruction
branch_taken  in  1  EX resolved a taken branch or jump this cycle
id_valid  out  1  IF/ID register holds a live instruction (registered)
id_inst  out  32  IF/ID instruction to the decoder and immediate generator (registered)
id_pc  out  PC_W  IF/ID PC (registered)
pc_write  out  1  PC update enable (combinational)
idex_bubble  out  1  ID/EX loads a NOP/zero-control bundle this cycle (combinational)
stall_cnt  out  CNT_W  cycles with pc_write=0, saturating
flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Reset values: id_valid=0, id_inst=32'h00000013 (addi x0,x0,0), id_pc=0, stall_cnt=0, flush_cnt=0, state=RUN, stall down-counter=0. Reset asserted mid-stall aborts the stall.
- Source-register usage is decoded from id_inst[6:0]:
  - rs1 is used by R, I-ALU, LOAD, S, B and JALR.
  - rs1 is not used by LUI, AUIPC or JAL, or by any unknown opcode.
  - rs2 is used only by R, S and B.
- hazard = id_valid & ex_mem_read & (ex_rd≠0) & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)). hazard is evaluated only in RUN.
- FSM states are RUN and STALL.
- RUN, no hazard, no branch_taken:
  - pc_write=1, idex_bubble=0.
  - IF/ID ← {if_inst, if_pc, if_valid}.
  - When if_valid=0, id_inst ← NOP.
- RUN, hazard, branch_taken=0:
  - pc_write=0, idex_bubble=1; IF/ID holds.
  - If STALL_CYC=1, remain in RUN (the next cycle re-evaluates with EX holding the bubble).
  - Otherwise go to STALL with the down-counter = STALL_CYC-1.
- STALL:
  - pc_write=0, idex_bubble=1; IF/ID holds; ex_* inputs are ignored.
  - The down-counter decrements each cycle; when it equals 1, next state is RUN.
  - Total stall length is exactly STALL_CYC cycles.
- branch_taken=1 in any state has highest priority over hazard and STALL:
  - pc_write=1 (PC loads the target via the external mux), idex_bubble=1.
  - Next cycle: id_valid=0, id_inst=NOP, id_pc=0, state=RUN, down-counter cleared.
  - flush_cnt +1.
- stall_cnt +1 on every cycle where pc_write=0; it never increments on a flush cycle. Both counters saturate at all-ones with no wrap.
- Latency: the IF/ID register is one cycle; pc_write and idex_bubble are same-cycle combinational from the registered state and the inputs.
- Bubbles never reach id_valid. A held instruction stays valid and unchanged throughout a stall.

Decomposition:
- riscv_pkg holds:
  - opcode constants OP_R 0110011, OP_IMM 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111, OP_JALR 1100111, OP_LUI 0110111, OP_AUIPC 0010111;
  - NOP_INST = 32'h00000013;
  - the FSM enum typedef hz_state_t {RUN, STALL}.
- One combinational sub-module, load_use_detect: inputs inst, ex_mem_read, ex_rd; output hazard. It contains the rs1/rs2 usage decode and the compares, and is reused by the verification scoreboard.

Test Plan:
- Reset check: hold reset 2 cycles → id_valid=0, id_inst=0x00000013, stall_cnt=flush_cnt=0, pc_write=1, idex_bubble=0.
- Load-use on rs1, STALL_CYC=1: id_inst=0x002081B3 (add x3,x1,x2), ex_mem_read=1, ex_rd=1 → exactly one cycle with pc_write=0 and idex_bubble=1; id_inst unchanged; stall_cnt=1; next fetched word loads the following cycle.
- rs2 and no-false-stall:
  - sw x1,0(x2)=0x00112023 with ex_rd=1 → stall.
  - lui x5,0x8=0x000082B7 (rs1 field=1) with ex_rd=1 → no stall.
  - any match with ex_rd=0 → no stall.
- Multi-cycle stall, STALL_CYC=3: hazard → pc_write=0 for exactly 3 cycles, then 1; stall_cnt=3. Repeat, asserting reset in the 2nd stall cycle → next cycle RUN, counters 0.
- Branch vs hazard in the same cycle: hazard true and branch_taken=1 → pc_write=1, idex_bubble=1; next cycle id_valid=0, id_inst=0x00000013, flush_cnt=1, stall_cnt unchanged.
- Branch during STALL (STALL_CYC=3) plus counter saturation:
  - branch_taken in the 2nd stall cycle → immediate exit to RUN, flush as above.
  - With CNT_W=2, force 5 stalls → stall_cnt holds at 3.
